// File: rtl/pipe_pkg.sv
// Shared definitions for the ID->EX stage: default widths, ALU op-codes,
// the default-width payload record and a payload-width helper.
package pipe_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned OP_W   = 3;

    // ALU op-codes carried in the Op field
    localparam logic [OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [OP_W-1:0] OP_AND = 3'd2;
    localparam logic [OP_W-1:0] OP_OR  = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR = 3'd4;
    localparam logic [OP_W-1:0] OP_SLL = 3'd5;
    localparam logic [OP_W-1:0] OP_SRL = 3'd6;
    localparam logic [OP_W-1:0] OP_SLT = 3'd7;

    typedef struct packed {
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
        logic [DATA_W-1:0] imm;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rsd;
        logic [OP_W-1:0]   Op;
    } id_ex_payload_t;

    // Total packed payload width for a given set of field widths
    function automatic int unsigned payload_w(input int unsigned dw,
                                              input int unsigned rw,
                                              input int unsigned ow);
        return (3 * dw) + (3 * rw) + ow;
    endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-entry valid/ready stage register. Main slot M drives the outputs,
// skid slot S absorbs the one instruction that arrives while EX stalls, so
// in_ready_o comes straight from a flop. Flush empties both slots.
module pipe_skid_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]   state_r;
    logic [1:0]   state_nxt_s;
    logic [W-1:0] m_data_r;
    logic [W-1:0] s_data_r;
    logic         m_valid_r;
    logic         in_ready_r;
    logic         acc_s;
    logic         pop_s;
    logic         m_load_in_s;
    logic         m_load_skid_s;
    logic         s_load_s;

    assign acc_s       = in_valid_i & in_ready_r;
    assign pop_s       = m_valid_r & out_ready_i;
    assign in_ready_o  = in_ready_r;
    assign out_valid_o = m_valid_r;
    assign out_data_o  = m_data_r;

    // Occupancy transitions and slot load selects; flush overrides everything
    always_comb begin
        state_nxt_s   = state_r;
        m_load_in_s   = 1'b0;
        m_load_skid_s = 1'b0;
        s_load_s      = 1'b0;
        if (flush_i) begin
            state_nxt_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (acc_s) begin
                        m_load_in_s = 1'b1;
                        state_nxt_s = ST_ONE;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (acc_s && pop_s) begin
                        m_load_in_s = 1'b1;
                        state_nxt_s = ST_ONE;
                    end else if (acc_s) begin
                        s_load_s    = 1'b1;
                        state_nxt_s = ST_TWO;
                    end else if (pop_s) begin
                        state_nxt_s = ST_EMPTY;
                    end else begin
                        state_nxt_s = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (pop_s) begin
                        m_load_skid_s = 1'b1;
                        state_nxt_s   = ST_ONE;
                    end else begin
                        state_nxt_s = ST_TWO;
                    end
                end
                default: begin
                    state_nxt_s = ST_EMPTY;
                end
            endcase
        end
    end

    // Occupancy state plus the registered valid/ready flags derived from it
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r    <= ST_EMPTY;
            m_valid_r  <= 1'b0;
            in_ready_r <= 1'b1;
        end else begin
            state_r    <= state_nxt_s;
            m_valid_r  <= (state_nxt_s != ST_EMPTY);
            in_ready_r <= (state_nxt_s != ST_TWO);
        end
    end

    // Main slot payload: new input, or the older skid entry (never bypassed)
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            m_data_r <= '0;
        end else if (m_load_in_s) begin
            m_data_r <= in_data_i;
        end else if (m_load_skid_s) begin
            m_data_r <= s_data_r;
        end else begin
            m_data_r <= m_data_r;
        end
    end

    // Skid slot payload: captured only when EX stalls with M occupied
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            s_data_r <= '0;
        end else if (s_load_s) begin
            s_data_r <= in_data_i;
        end else begin
            s_data_r <= s_data_r;
        end
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register: packs the decoded instruction into one payload
// vector, passes it through the skid register and counts producer stalls.
module id_ex_pipe_reg #(
    parameter int unsigned DATA_W = pipe_pkg::DATA_W,
    parameter int unsigned REG_AW = pipe_pkg::REG_AW,
    parameter int unsigned OP_W   = pipe_pkg::OP_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] rs1_data_i,
    input  logic [DATA_W-1:0] rs2_data_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [REG_AW-1:0] rs1_i,
    input  logic [REG_AW-1:0] rs2_i,
    input  logic [REG_AW-1:0] rsd_i,
    input  logic [OP_W-1:0]   Op_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] rs1_data_o,
    output logic [DATA_W-1:0] rs2_data_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [REG_AW-1:0] rs1_o,
    output logic [REG_AW-1:0] rs2_o,
    output logic [REG_AW-1:0] rsd_o,
    output logic [OP_W-1:0]   Op_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    import pipe_pkg::*;

    localparam int unsigned     PAY_W   = payload_w(DATA_W, REG_AW, OP_W);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Same field order as id_ex_payload_t, but sized by this instance
    typedef struct packed {
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
        logic [DATA_W-1:0] imm;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rsd;
        logic [OP_W-1:0]   Op;
    } payload_t;

    payload_t         in_pay_s;
    payload_t         out_pay_s;
    logic [PAY_W-1:0] out_vec_s;
    logic             in_ready_s;
    logic [CNT_W-1:0] stall_cnt_r;

    assign in_pay_s.rs1_data = rs1_data_i;
    assign in_pay_s.rs2_data = rs2_data_i;
    assign in_pay_s.imm      = imm_i;
    assign in_pay_s.rs1      = rs1_i;
    assign in_pay_s.rs2      = rs2_i;
    assign in_pay_s.rsd      = rsd_i;
    assign in_pay_s.Op       = Op_i;

    pipe_skid_reg #(
        .W (PAY_W)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_s),
        .in_data_i   (in_pay_s),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_vec_s)
    );

    assign out_pay_s   = out_vec_s;
    assign in_ready_o  = in_ready_s;
    assign rs1_data_o  = out_pay_s.rs1_data;
    assign rs2_data_o  = out_pay_s.rs2_data;
    assign imm_o       = out_pay_s.imm;
    assign rs1_o       = out_pay_s.rs1;
    assign rs2_o       = out_pay_s.rs2;
    assign rsd_o       = out_pay_s.rsd;
    assign Op_o        = out_pay_s.Op;
    assign stall_cnt_o = stall_cnt_r;

    // Count refused offers; saturates, and survives flush (reset clears it)
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_r <= '0;
        end else if (in_valid_i && !in_ready_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: a wide instance (64/6, 16-bit counter) and a
// narrow instance (32/5, 4-bit counter) share one stimulus stream and one
// queue-based reference model.
module tb_id_ex_pipe_reg;

    typedef struct packed {
        logic [63:0] rs1d;
        logic [63:0] rs2d;
        logic [63:0] imm;
        logic [5:0]  rs1;
        logic [5:0]  rs2;
        logic [5:0]  rsd;
        logic [2:0]  op;
    } pl_t;

    logic clk = 1'b0;
    logic rst_i, flush_i, in_valid_i, out_ready_i;
    pl_t  in_pl;

    logic        w_ready, w_valid;
    logic [63:0] w_rs1d, w_rs2d, w_imm;
    logic [5:0]  w_rs1, w_rs2, w_rsd;
    logic [2:0]  w_op;
    logic [15:0] w_cnt;

    logic        n_ready, n_valid;
    logic [31:0] n_rs1d, n_rs2d, n_imm;
    logic [4:0]  n_rs1, n_rs2, n_rsd;
    logic [2:0]  n_op;
    logic [3:0]  n_cnt;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // reference model state
    pl_t q[$];
    pl_t last_m = '0;
    int  cnt16 = 0;
    int  cnt4  = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.DATA_W(64), .REG_AW(6), .OP_W(3), .CNT_W(16)) dut_w (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(w_ready),
        .rs1_data_i(in_pl.rs1d), .rs2_data_i(in_pl.rs2d), .imm_i(in_pl.imm),
        .rs1_i(in_pl.rs1), .rs2_i(in_pl.rs2), .rsd_i(in_pl.rsd), .Op_i(in_pl.op),
        .out_valid_o(w_valid), .out_ready_i(out_ready_i),
        .rs1_data_o(w_rs1d), .rs2_data_o(w_rs2d), .imm_o(w_imm),
        .rs1_o(w_rs1), .rs2_o(w_rs2), .rsd_o(w_rsd), .Op_o(w_op),
        .stall_cnt_o(w_cnt)
    );

    id_ex_pipe_reg #(.DATA_W(32), .REG_AW(5), .OP_W(3), .CNT_W(4)) dut_n (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(n_ready),
        .rs1_data_i(in_pl.rs1d[31:0]), .rs2_data_i(in_pl.rs2d[31:0]), .imm_i(in_pl.imm[31:0]),
        .rs1_i(in_pl.rs1[4:0]), .rs2_i(in_pl.rs2[4:0]), .rsd_i(in_pl.rsd[4:0]), .Op_i(in_pl.op),
        .out_valid_o(n_valid), .out_ready_i(out_ready_i),
        .rs1_data_o(n_rs1d), .rs2_data_o(n_rs2d), .imm_o(n_imm),
        .rs1_o(n_rs1), .rs2_o(n_rs2), .rsd_o(n_rsd), .Op_o(n_op),
        .stall_cnt_o(n_cnt)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic pl_t rand_pl();
        pl_t p;
        p.rs1d = {$urandom, $urandom};
        p.rs2d = {$urandom, $urandom};
        p.imm  = {$urandom, $urandom};
        p.rs1  = 6'($urandom);
        p.rs2  = 6'($urandom);
        p.rsd  = 6'($urandom);
        p.op   = 3'($urandom);
        return p;
    endfunction

    // Reference model: an in-order queue of at most two instructions
    always @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            q.delete();
            last_m = '0;
            cnt16  = 0;
            cnt4   = 0;
        end else begin
            int  n;
            bit  acc, pop;
            n   = q.size();
            acc = in_valid_i && (n < 2);
            pop = (n > 0) && out_ready_i;
            if (in_valid_i && (n == 2)) begin
                if (cnt16 < 65535) cnt16++;
                if (cnt4 < 15) cnt4++;
            end
            if (flush_i) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (acc) q.push_back(in_pl);
            end
            if (q.size() > 0) last_m = q[0];
        end
    end

    // Compare both instances against the model every cycle
    always @(negedge clk) begin
        if (chk_en) begin
            chk("w_valid", 64'(w_valid), 64'(q.size() > 0));
            chk("w_ready", 64'(w_ready), 64'(q.size() < 2));
            chk("w_rs1d",  w_rs1d, last_m.rs1d);
            chk("w_rs2d",  w_rs2d, last_m.rs2d);
            chk("w_imm",   w_imm,  last_m.imm);
            chk("w_regs",  64'({w_rs1, w_rs2, w_rsd, w_op}),
                64'({last_m.rs1, last_m.rs2, last_m.rsd, last_m.op}));
            chk("w_cnt",   64'(w_cnt), 64'(cnt16));
            chk("n_valid", 64'(n_valid), 64'(q.size() > 0));
            chk("n_ready", 64'(n_ready), 64'(q.size() < 2));
            chk("n_data",  {n_rs1d, n_imm}, {last_m.rs1d[31:0], last_m.imm[31:0]});
            chk("n_rs2d",  64'(n_rs2d), 64'(last_m.rs2d[31:0]));
            chk("n_regs",  64'({n_rs1, n_rs2, n_rsd, n_op}),
                64'({last_m.rs1[4:0], last_m.rs2[4:0], last_m.rsd[4:0], last_m.op}));
            chk("n_cnt",   64'(n_cnt), 64'(cnt4));
        end
    end

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        in_pl = '0;
        #1 rst_i = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst_i = 1'b1;

        // fill both slots, then reset mid-transfer
        in_valid_i = 1'b1; in_pl = rand_pl();
        @(negedge clk);
        in_pl = rand_pl();
        @(negedge clk);
        #2 rst_i = 1'b0;
        #1;
        chk("rst_valid", 64'(w_valid), 64'd0);
        chk("rst_ready", 64'(w_ready), 64'd1);
        chk("rst_imm",   w_imm, 64'd0);
        chk("rst_rsd",   64'(w_rsd), 64'd0);
        chk("rst_cnt",   64'(w_cnt), 64'd0);
        @(negedge clk);
        rst_i = 1'b1;

        // back-to-back stream with EX always ready
        for (int i = 1; i <= 4; i++) begin
            in_pl = rand_pl(); in_pl.rsd = 6'(i);
            in_valid_i = 1'b1; out_ready_i = 1'b1;
            @(negedge clk);
            chk("stream_rsd",   64'(w_rsd), 64'(i));
            chk("stream_valid", 64'(w_valid), 64'd1);
            chk("stream_ready", 64'(w_ready), 64'd1);
        end
        in_valid_i = 1'b0;
        @(negedge clk);
        chk("stream_drain", 64'(w_valid), 64'd0);

        // back-pressure: two accepts fill the stage, then three stall cycles
        out_ready_i = 1'b0; in_valid_i = 1'b1;
        in_pl = rand_pl(); in_pl.rsd = 6'd5;
        @(negedge clk);
        chk("bp_rsd5",  64'(w_rsd), 64'd5);
        chk("bp_ready1", 64'(w_ready), 64'd1);
        in_pl = rand_pl(); in_pl.rsd = 6'd6;
        @(negedge clk);
        chk("bp_ready0", 64'(w_ready), 64'd0);
        in_pl = rand_pl(); in_pl.rsd = 6'd7;
        repeat (3) @(negedge clk);
        chk("bp_cnt",   64'(w_cnt), 64'd3);
        chk("bp_cnt_n", 64'(n_cnt), 64'd3);
        chk("bp_head",  64'(w_rsd), 64'd5);
        in_valid_i = 1'b0; out_ready_i = 1'b1;
        @(negedge clk);
        chk("bp_rsd6",  64'(w_rsd), 64'd6);
        chk("bp_v6",    64'(w_valid), 64'd1);
        @(negedge clk);
        chk("bp_empty", 64'(w_valid), 64'd0);

        // flush while full with a simultaneous offer (rsd 9)
        out_ready_i = 1'b0; in_valid_i = 1'b1;
        in_pl = rand_pl(); in_pl.rsd = 6'd10;
        @(negedge clk);
        in_pl = rand_pl(); in_pl.rsd = 6'd11;
        @(negedge clk);
        flush_i = 1'b1; in_pl = rand_pl(); in_pl.rsd = 6'd9;
        @(negedge clk);
        chk("fl2_valid", 64'(w_valid), 64'd0);
        chk("fl2_ready", 64'(w_ready), 64'd1);
        flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("fl2_no9", 64'(w_valid), 64'd0);
        end

        // flush beats a pop in the one-entry state
        out_ready_i = 1'b0; in_valid_i = 1'b1;
        in_pl = rand_pl(); in_pl.rsd = 6'd12;
        @(negedge clk);
        chk("fl1_rsd", 64'(w_rsd), 64'd12);
        in_valid_i = 1'b0; out_ready_i = 1'b1; flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        chk("fl1_valid", 64'(w_valid), 64'd0);
        chk("fl1_ready", 64'(w_ready), 64'd1);
        chk("fl1_cnt",   64'(w_cnt), 64'd4);

        // saturation: 2 fills + 20 stalls, then 3 more
        out_ready_i = 1'b0; in_valid_i = 1'b1;
        for (int i = 0; i < 22; i++) begin
            in_pl = rand_pl();
            @(negedge clk);
        end
        chk("sat_n",  64'(n_cnt), 64'd15);
        chk("sat_w",  64'(w_cnt), 64'd24);
        repeat (3) @(negedge clk);
        chk("sat_n_hold", 64'(n_cnt), 64'd15);
        chk("sat_w_more", 64'(w_cnt), 64'd27);
        in_valid_i = 1'b0; flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;

        // wide payload passes bit-exact
        in_pl = rand_pl();
        in_pl.imm = 64'hDEAD_BEEF_0123_4567; in_pl.rsd = 6'd63;
        in_valid_i = 1'b1; out_ready_i = 1'b1;
        @(negedge clk);
        chk("imm_w",  w_imm, 64'hDEAD_BEEF_0123_4567);
        chk("imm_n",  64'(n_imm), 64'h0000_0000_0123_4567);
        chk("rsd_w",  64'(w_rsd), 64'd63);
        chk("rsd_n",  64'(n_rsd), 64'd31);
        in_valid_i = 1'b0;
        @(negedge clk);

        // random valid/ready/flush traffic
        for (int c = 0; c < 10000; c++) begin
            in_pl       = rand_pl();
            in_valid_i  = ($urandom_range(0, 9) < 7);
            out_ready_i = ($urandom_range(0, 9) < 6);
            flush_i     = ($urandom_range(0, 63) == 0);
            @(negedge clk);
        end
        in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("final_empty", 64'(w_valid), 64'd0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
